// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs a one-hot type selector and register/immediate
// fields into a 32-bit word, tags it with an instruction-memory byte address, and streams it out through an output register backed by one skid register.
module instr_encoder #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        restart_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic        r_type_i,
   input  logic        i_type_i,
   input  logic        load_i,
   input  logic        store_i,
   input  logic        branch_i,
   input  logic        jal_i,
   input  logic        jalr_i,
   input  logic        lui_i,
   input  logic        auipc_i,
   input  logic [4:0]  rd_i,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   input  logic [2:0]  funct3_i,
   input  logic [6:0]  funct7_i,
   input  logic [31:0] imm_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] out_instr_o,
   output logic [31:0] out_addr_o,
   output logic        err_o,
   output logic [7:0]  err_cnt_o
);

   logic [8:0]  sel;
   logic        sel_ok;
   logic [31:0] enc;
   logic        accept, good, bad;

   logic        out_valid_q, out_valid_d;
   logic [31:0] out_instr_q, out_instr_d;
   logic [31:0] out_addr_q,  out_addr_d;
   logic        skid_valid_q, skid_valid_d;
   logic [31:0] skid_instr_q, skid_instr_d;
   logic [31:0] skid_addr_q,  skid_addr_d;
   logic [31:0] addr_q, addr_d;
   logic        err_q, err_d;
   logic [7:0]  err_cnt_q, err_cnt_d;

   assign sel    = {auipc_i, lui_i, jalr_i, jal_i, branch_i, store_i, load_i, i_type_i, r_type_i};
   // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
   assign sel_ok = (sel != 9'd0) && ((sel & (sel - 9'd1)) == 9'd0);

   always_comb begin
      enc = 32'd0;
      if (r_type_i) begin
         enc = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, 7'b0110011};
      end else if (i_type_i) begin
         enc = {imm_i[11:0], rs1_i, funct3_i, rd_i, 7'b0010011};
         // Shift-immediate forms carry funct7 in the upper immediate bits.
         if (funct3_i[1:0] == 2'b01) begin
            enc[31:25] = funct7_i;
         end
      end else if (load_i) begin
         enc = {imm_i[11:0], rs1_i, funct3_i, rd_i, 7'b0000011};
      end else if (store_i) begin
         enc = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], 7'b0100011};
      end else if (branch_i) begin
         enc = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11], 7'b1100011};
      end else if (jal_i) begin
         enc = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, 7'b1101111};
      end else if (jalr_i) begin
         enc = {imm_i[11:0], rs1_i, 3'b000, rd_i, 7'b1100111};
      end else if (lui_i) begin
         enc = {imm_i[31:12], rd_i, 7'b0110111};
      end else if (auipc_i) begin
         enc = {imm_i[31:12], rd_i, 7'b0010111};
      end
   end

   assign in_ready_o = !skid_valid_q;
   assign accept     = in_valid_i && in_ready_o;
   assign good       = accept && sel_ok;
   assign bad        = accept && !sel_ok;

   always_comb begin
      out_valid_d  = out_valid_q;
      out_instr_d  = out_instr_q;
      out_addr_d   = out_addr_q;
      skid_valid_d = skid_valid_q;
      skid_instr_d = skid_instr_q;
      skid_addr_d  = skid_addr_q;
      addr_d       = addr_q;
      err_d        = err_q;
      err_cnt_d    = err_cnt_q;

      if (!out_valid_q || out_ready_i) begin
         // Output register is free this edge; a buffered skid word has priority
         // (no new beat can be accepted while the skid register is full).
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_instr_d  = skid_instr_q;
            out_addr_d   = skid_addr_q;
            skid_valid_d = 1'b0;
         end else if (good) begin
            out_valid_d = 1'b1;
            out_instr_d = enc;
            out_addr_d  = addr_q;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (good) begin
         skid_valid_d = 1'b1;
         skid_instr_d = enc;
         skid_addr_d  = addr_q;
      end

      // A beat accepted alongside restart still uses the pre-restart address.
      if (restart_i) begin
         addr_d = BASE_ADDR;
      end else if (good) begin
         addr_d = addr_q + 32'd4;
      end

      if (bad) begin
         err_d = 1'b1;
         if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_valid_q  <= 1'b0;
         out_instr_q  <= 32'd0;
         out_addr_q   <= BASE_ADDR;
         skid_valid_q <= 1'b0;
         skid_instr_q <= 32'd0;
         skid_addr_q  <= 32'd0;
         addr_q       <= BASE_ADDR;
         err_q        <= 1'b0;
         err_cnt_q    <= 8'd0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_instr_q  <= out_instr_d;
         out_addr_q   <= out_addr_d;
         skid_valid_q <= skid_valid_d;
         skid_instr_q <= skid_instr_d;
         skid_addr_q  <= skid_addr_d;
         addr_q       <= addr_d;
         err_q        <= err_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_instr_o = out_instr_q;
   assign out_addr_o  = out_addr_q;
   assign err_o       = err_q;
   assign err_cnt_o   = err_cnt_q;

endmodule
